// File: rtl/fmul_post.sv
// Post-multiply fix-up stage: IEEE special cases and exponent range clamping, buffered in a
// small valid/ready FIFO. Optional pop-side flag counters under FMUL_POST_STATS_EN.
module fmul_post #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [31:0]      y_raw,
  input  logic             ovf_raw,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [3:0]       flags,
  output logic [TAG_W-1:0] tag_out
`ifdef FMUL_POST_STATS_EN
  ,
  output logic [15:0]      nv_cnt,
  output logic [15:0]      of_cnt,
  output logic [15:0]      uf_cnt
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned EntW = 32 + 4 + TAG_W;

  logic        sign;
  logic [7:0]  e1, e2;
  logic        nan1, nan2, inf1, inf2, zero1, zero2;
  logic [1:0]  adj;
  logic signed [10:0] exp_e;
  logic [31:0] fix_y;
  logic        fix_nv, fix_of, fix_uf, fix_zero;
  logic        unused_ok;

  assign unused_ok = y_raw[31];

  always_comb begin
    sign  = x1[31] ^ x2[31];
    e1    = x1[30:23];
    e2    = x2[30:23];
    nan1  = (&e1) && (|x1[22:0]);
    nan2  = (&e2) && (|x2[22:0]);
    inf1  = (&e1) && !(|x1[22:0]);
    inf2  = (&e2) && !(|x2[22:0]);
    zero1 = !(|e1);
    zero2 = !(|e2);
    // Only the low two bits of the normalisation shift matter; 129 mod 4 = 1.
    adj   = y_raw[24:23] - (e1[1:0] + e2[1:0] + 2'd1);
    exp_e = $signed({3'b000, e1}) + $signed({3'b000, e2}) - 11'sd127
            + $signed({9'b0, adj});

    fix_y    = '0;
    fix_nv   = 1'b0;
    fix_of   = 1'b0;
    fix_uf   = 1'b0;
    fix_zero = 1'b0;
    if (nan1 || nan2) begin
      fix_y  = 32'h7FC0_0000;
      fix_nv = 1'b1;
    end else if ((inf1 && zero2) || (inf2 && zero1)) begin
      fix_y  = 32'h7FC0_0000;
      fix_nv = 1'b1;
    end else if (inf1 || inf2) begin
      fix_y = {sign, 8'hFF, 23'h0};
    end else if (zero1 || zero2) begin
      fix_y    = {sign, 31'h0};
      fix_zero = 1'b1;
    end else if (exp_e >= 11'sd255) begin
      fix_y  = {sign, 8'hFF, 23'h0};
      fix_of = 1'b1;
    end else if (exp_e <= 11'sd0) begin
      fix_y    = {sign, 31'h0};
      fix_uf   = 1'b1;
      fix_zero = 1'b1;
    end else begin
      fix_y = {sign, exp_e[7:0], y_raw[22:0]};
    end
    fix_of = fix_of | ovf_raw;
  end

  logic [EntW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop;
  logic [EntW-1:0] head;

  assign out_valid = (count_q != '0);
  assign in_ready  = (count_q < CntW'(DEPTH)) | out_ready;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    {y, flags, tag_out} = out_valid ? head : '0;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the count gates every read.
  always_ff @(posedge clk) begin
    if (push && !rstn) begin
      mem_q[wr_ptr_q] <= {fix_y, fix_nv, fix_of, fix_uf, fix_zero, tag_in};
    end
  end

`ifdef FMUL_POST_STATS_EN
  logic [15:0] nv_cnt_q, of_cnt_q, uf_cnt_q;

  always_ff @(posedge clk) begin
    if (rstn) begin
      nv_cnt_q <= '0;
      of_cnt_q <= '0;
      uf_cnt_q <= '0;
    end else if (pop) begin
      if (flags[3] && nv_cnt_q != 16'hFFFF) nv_cnt_q <= nv_cnt_q + 16'd1;
      if (flags[2] && of_cnt_q != 16'hFFFF) of_cnt_q <= of_cnt_q + 16'd1;
      if (flags[1] && uf_cnt_q != 16'hFFFF) uf_cnt_q <= uf_cnt_q + 16'd1;
    end
  end

  assign nv_cnt = nv_cnt_q;
  assign of_cnt = of_cnt_q;
  assign uf_cnt = uf_cnt_q;
`endif

endmodule

// File: tb/tb_fmul_post.sv
// Self-checking bench for fmul_post: directed test-plan vectors plus a randomized
// scoreboard run against a behavioural fix-up model.
module tb_fmul_post;
  localparam int TW = 5;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          in_valid, in_ready;
  logic [31:0]   x1, x2, y_raw;
  logic          ovf_raw;
  logic [TW-1:0] tag_in;
  logic          out_valid, out_ready;
  logic [31:0]   y;
  logic [3:0]    flags;
  logic [TW-1:0] tag_out;
`ifdef FMUL_POST_STATS_EN
  logic [15:0]   nv_cnt, of_cnt, uf_cnt;
  int            exp_nv, exp_of, exp_uf;
`endif

  int checks = 0;
  int failures = 0;

  fmul_post #(.TAG_W(TW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .y_raw     (y_raw),
    .ovf_raw   (ovf_raw),
    .tag_in    (tag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .flags     (flags),
    .tag_out   (tag_out)
`ifdef FMUL_POST_STATS_EN
    ,
    .nv_cnt    (nv_cnt),
    .of_cnt    (of_cnt),
    .uf_cnt    (uf_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model: returns {y, nv, of, uf, zero}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] r, input logic ovf);
    int ea = int'(a[30:23]);
    int eb = int'(b[30:23]);
    int er = int'(r[30:23]);
    int c, big_e;
    logic s = a[31] ^ b[31];
    bit nan_any = (ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0);
    bit inf_a = (ea == 255 && a[22:0] == 0);
    bit inf_b = (eb == 255 && b[22:0] == 0);
    logic [31:0] ry;
    logic [3:0] rf = 4'b0000;
    c = ((er - ((ea + eb + 129) % 256)) + 256) % 256;
    big_e = ea + eb - 127 + (c % 4);
    if (nan_any || (inf_a && eb == 0) || (inf_b && ea == 0)) begin
      ry = 32'h7FC00000; rf[3] = 1'b1;
    end else if (inf_a || inf_b) begin
      ry = {s, 31'h7F800000};
    end else if (ea == 0 || eb == 0) begin
      ry = {s, 31'h0}; rf[0] = 1'b1;
    end else if (big_e >= 255) begin
      ry = {s, 31'h7F800000}; rf[2] = 1'b1;
    end else if (big_e <= 0) begin
      ry = {s, 31'h0}; rf[1] = 1'b1; rf[0] = 1'b1;
    end else begin
      ry = {s, 8'(big_e), r[22:0]};
    end
    if (ovf) rf[2] = 1'b1;
    return {ry, rf};
  endfunction

  // Push one operation into an empty FIFO, capture the head after the edge, then drain it.
  task automatic do_single(input logic [31:0] a, input logic [31:0] b, input logic [31:0] r,
                           input logic ovf, input logic [TW-1:0] t, output logic v,
                           output logic [31:0] oy, output logic [3:0] ofl,
                           output logic [TW-1:0] ot);
    @(negedge clk);
    x1 = a; x2 = b; y_raw = r; ovf_raw = ovf; tag_in = t;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    v = out_valid; oy = y; ofl = flags; ot = tag_out;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x1 = '0; x2 = '0; y_raw = '0; ovf_raw = 1'b0; tag_in = '0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'h0 || flags !== 4'h0 || tag_out !== '0
        || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got v=%b y=%h f=%b t=%0d rdy=%b exp v=0 y=0 f=0 t=0 rdy=1",
               out_valid, y, flags, tag_out, in_ready);
    end
  endtask

  task automatic test_directed;
    logic v; logic [31:0] oy; logic [3:0] ofl; logic [TW-1:0] ot;
    do_single(32'h40000000, 32'h40400000, 32'h40C00000, 1'b0, 5'd3, v, oy, ofl, ot);
    checks++;
    if (v !== 1'b1 || oy !== 32'h40C00000 || ofl !== 4'b0000 || ot !== 5'd3) begin
      failures++;
      $display("FAIL mul_2x3 got v=%b y=%h f=%b t=%0d exp v=1 y=40c00000 f=0000 t=3",
               v, oy, ofl, ot);
    end
    do_single(32'h7F800000, 32'h00000000, 32'h12345678, 1'b0, 5'd4, v, oy, ofl, ot);
    checks++;
    if (oy !== 32'h7FC00000 || ofl !== 4'b1000) begin
      failures++;
      $display("FAIL inf_x_zero got y=%h f=%b exp y=7fc00000 f=1000", oy, ofl);
    end
    do_single(32'h00000000, 32'h7F800000, 32'h12345678, 1'b0, 5'd5, v, oy, ofl, ot);
    checks++;
    if (oy !== 32'h7FC00000 || ofl !== 4'b1000) begin
      failures++;
      $display("FAIL zero_x_inf got y=%h f=%b exp y=7fc00000 f=1000", oy, ofl);
    end
    do_single(32'h7F000000, 32'h7F000000, 32'h7E000000, 1'b0, 5'd6, v, oy, ofl, ot);
    checks++;
    if (oy !== 32'h7F800000 || ofl !== 4'b0100) begin
      failures++;
      $display("FAIL overflow_pos got y=%h f=%b exp y=7f800000 f=0100", oy, ofl);
    end
    do_single(32'hFF000000, 32'h7F000000, 32'h7E000000, 1'b0, 5'd7, v, oy, ofl, ot);
    checks++;
    if (oy !== 32'hFF800000 || ofl !== 4'b0100) begin
      failures++;
      $display("FAIL overflow_neg got y=%h f=%b exp y=ff800000 f=0100", oy, ofl);
    end
    do_single(32'h00800000, 32'h00800000, 32'h00800000, 1'b0, 5'd8, v, oy, ofl, ot);
    checks++;
    if (oy !== 32'h00000000 || ofl !== 4'b0011) begin
      failures++;
      $display("FAIL underflow got y=%h f=%b exp y=00000000 f=0011", oy, ofl);
    end
    do_single(32'h7FC00001, 32'h40000000, 32'h0, 1'b1, 5'd9, v, oy, ofl, ot);
    checks++;
    if (oy !== 32'h7FC00000 || ofl !== 4'b1100) begin
      failures++;
      $display("FAIL nan_with_ovf got y=%h f=%b exp y=7fc00000 f=1100", oy, ofl);
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] held_y;
    out_ready = 1'b0;
    x1 = 32'h40000000; x2 = 32'h40400000; y_raw = 32'h40C00000; ovf_raw = 1'b0;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      in_valid = 1'b1; tag_in = TW'(t);
      @(posedge clk);
    end
    @(negedge clk);
    tag_in = 5'd3; #1;
    held_y = y;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || tag_out !== 5'd1) begin
      failures++;
      $display("FAIL bp_full got rdy=%b v=%b t=%0d exp rdy=0 v=1 t=1", in_ready, out_valid,
               tag_out);
    end
    @(negedge clk); #1;
    checks++;
    if (tag_out !== 5'd1 || y !== held_y || flags !== 4'b0000) begin
      failures++;
      $display("FAIL bp_stable got t=%0d y=%h exp t=1 y=%h", tag_out, y, held_y);
    end
    out_ready = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_path got rdy=%b exp rdy=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int t = 2; t <= 3; t++) begin
      checks++;
      if (out_valid !== 1'b1 || tag_out !== TW'(t)) begin
        failures++;
        $display("FAIL bp_order got v=%b t=%0d exp v=1 t=%0d", out_valid, tag_out, t);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'h0 || tag_out !== '0) begin
      failures++;
      $display("FAIL bp_drained got v=%b y=%h t=%0d exp v=0 y=0 t=0", out_valid, y, tag_out);
    end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    x1 = 32'hC0000000; x2 = 32'h40400000; y_raw = 32'h40C00000; ovf_raw = 1'b1;
    for (int t = 11; t <= 12; t++) begin
      @(negedge clk);
      in_valid = 1'b1; tag_in = TW'(t);
      @(posedge clk);
    end
    @(negedge clk);
    rstn = 1'b1; out_ready = 1'b1; in_valid = 1'b1; tag_in = 5'd9;
    @(posedge clk); #1;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || y !== 32'h0 || flags !== 4'h0 || tag_out !== '0
        || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid got v=%b y=%h f=%b t=%0d rdy=%b exp v=0 y=0 f=0 t=0 rdy=1",
               out_valid, y, flags, tag_out, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; tag_in = 5'd7; ovf_raw = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || tag_out !== 5'd7 || y !== 32'hC0C00000) begin
      failures++;
      $display("FAIL reset_new_head got v=%b t=%0d y=%h exp v=1 t=7 y=c0c00000",
               out_valid, tag_out, y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_only_new got v=%b exp v=0", out_valid);
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic [7:0] e;
    logic [22:0] m;
    case ($urandom_range(0, 7))
      0: e = 8'd0;
      1: e = 8'd255;
      2: e = 8'd1;
      3: e = 8'd254;
      default: e = 8'($urandom);
    endcase
    m = ($urandom_range(0, 3) == 0) ? 23'h0 : 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  task automatic test_random;
    logic [35+TW:0] q[$];
    logic [35:0] mres;
    bit exp_rdy, do_push, do_pop;
    int bad = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      x1 = rand_op(); x2 = rand_op(); y_raw = $urandom; ovf_raw = ($urandom_range(0, 7) == 0);
      tag_in = TW'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = (q.size() < DEPTH) || out_ready;
      checks++;
      if (in_ready !== exp_rdy || out_valid !== (q.size() != 0)) begin
        failures++; bad++;
        if (bad < 10)
          $display("FAIL rand_ctrl cyc=%0d got rdy=%b v=%b exp rdy=%b v=%b", i, in_ready,
                   out_valid, exp_rdy, q.size() != 0);
      end
      checks++;
      if (q.size() != 0 ? ({y, flags, tag_out} !== q[0]) : ({y, flags, tag_out} !== '0)) begin
        failures++; bad++;
        if (bad < 10)
          $display("FAIL rand_head cyc=%0d got y=%h f=%b t=%0d exp %h", i, y, flags, tag_out,
                   q.size() != 0 ? q[0] : '0);
      end
      do_pop = (q.size() != 0) && out_ready;
      do_push = in_valid && exp_rdy;
      if (do_pop) begin
`ifdef FMUL_POST_STATS_EN
        exp_nv += int'(q[0][TW+3]); exp_of += int'(q[0][TW+2]); exp_uf += int'(q[0][TW+1]);
`endif
        void'(q.pop_front());
      end
      if (do_push) begin
        mres = model(x1, x2, y_raw, ovf_raw);
        q.push_back({mres, tag_in});
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
`ifdef FMUL_POST_STATS_EN
    checks++;
    if (nv_cnt !== 16'(exp_nv) || of_cnt !== 16'(exp_of) || uf_cnt !== 16'(exp_uf)) begin
      failures++;
      $display("FAIL stats got nv=%0d of=%0d uf=%0d exp nv=%0d of=%0d uf=%0d", nv_cnt, of_cnt,
               uf_cnt, exp_nv, exp_of, exp_uf);
    end
`endif
  endtask

  initial begin
`ifdef FMUL_POST_STATS_EN
    exp_nv = 0; exp_of = 0; exp_uf = 0;
`endif
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
